icache_fetch_unit: RTL and testbench



---
 rtl/icache_fetch_unit.sv | 116 +++++++++++
 tb/tb_icache_fetch_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_unit.sv
// Cache-less instruction fetch: takes one FTQ request, reads N consecutive words
// over a single-outstanding memory port and hands the assembled packet to the IFU.
package global_config_pkg;
  typedef struct packed {
    int unsigned VLEN;
    int unsigned ILEN;
    int unsigned INSTR_PER_FETCH;
  } cfg_t;

  localparam cfg_t Cfg = '{VLEN: 32, ILEN: 32, INSTR_PER_FETCH: 4};

  typedef struct packed {
    logic                valid;
    logic [Cfg.VLEN-1:0] vaddr;
  } ftq2icache_req_t;

  typedef struct packed {
    logic ready;
  } icache2ftq_rsp_t;
endpackage

module icache_fetch_unit #(
  parameter global_config_pkg::cfg_t Cfg = global_config_pkg::Cfg
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  global_config_pkg::ftq2icache_req_t           ftq_req_i,
  output global_config_pkg::icache2ftq_rsp_t           ftq_rsp_o,
  output logic                                         mem_req_valid_o,
  input  logic                                         mem_req_ready_i,
  output logic [Cfg.VLEN-1:0]                          mem_req_addr_o,
  input  logic                                         mem_rsp_valid_i,
  input  logic [Cfg.ILEN-1:0]                          mem_rsp_data_i,
  output logic                                         ifu_rsp_valid_o,
  input  logic                                         ifu_rsp_ready_i,
  output logic [Cfg.VLEN-1:0]                          ifu_rsp_pc_o,
  output logic [Cfg.INSTR_PER_FETCH-1:0][Cfg.ILEN-1:0] ifu_rsp_data_o
);

  localparam int unsigned N    = Cfg.INSTR_PER_FETCH;
  localparam int unsigned VLEN = Cfg.VLEN;
  localparam int unsigned ILEN = Cfg.ILEN;
  localparam int unsigned WB   = ILEN / 8;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [VLEN-1:0]          base_q, base_d;
  logic [N-1:0][ILEN-1:0]   data_q, data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (ftq_req_i.valid && !flush_i) begin
          base_d  = ftq_req_i.vaddr;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush_i)              state_d = mem_req_ready_i ? DRAIN : IDLE;
        else if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (flush_i) begin
          state_d = mem_rsp_valid_i ? IDLE : DRAIN;
        end else if (mem_rsp_valid_i) begin
          data_d[cnt_q] = mem_rsp_data_i;
          if (cnt_q == CW'(N - 1)) begin
            state_d = RESP;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = REQ;
          end
        end
      end
      RESP: begin
        if (flush_i || ifu_rsp_ready_i) state_d = IDLE;
      end
      // A flush here only keeps us draining; the stale response must still retire.
      DRAIN: begin
        if (mem_rsp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ftq_rsp_o.ready = (state_q == IDLE) && !flush_i;
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_addr_o  = base_q + VLEN'(cnt_q) * VLEN'(WB);
  assign ifu_rsp_valid_o = (state_q == RESP);
  assign ifu_rsp_pc_o    = base_q;
  assign ifu_rsp_data_o  = data_q;

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed bench for icache_fetch_unit with a latency/stall-configurable memory model.
module tb_icache_fetch_unit;
  import global_config_pkg::*;

  logic clk = 1'b0;
  logic rst_ni, flush;
  ftq2icache_req_t ftq_req;
  icache2ftq_rsp_t ftq_rsp;
  logic mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_rsp_data;
  logic ifu_valid, ifu_ready;
  logic [31:0] ifu_pc;
  logic [3:0][31:0] ifu_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icache_fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .ftq_req_i(ftq_req), .ftq_rsp_o(ftq_rsp),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i(mem_rsp_data), .ifu_rsp_valid_o(ifu_valid),
    .ifu_rsp_ready_i(ifu_ready), .ifu_rsp_pc_o(ifu_pc), .ifu_rsp_data_o(ifu_data)
  );

  // memory model: data = address, response `lat` cycles after acceptance
  int lat = 1;
  int stall_left = 0;
  logic [31:0] stall_addr = '0;
  int cd = 0;
  logic [31:0] pend = '0;
  bit hs_seen = 0;
  logic [31:0] hs_addr = '0;

  initial begin
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  end

  always @(negedge clk) begin
    hs_seen = mem_req_valid && mem_req_ready;
    hs_addr = mem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    if (!rst_ni) begin
      cd = 0;
      mem_req_ready = 1'b1;
    end else begin
      if (hs_seen) begin cd = lat; pend = hs_addr; hs_seen = 0; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin mem_rsp_valid = 1'b1; mem_rsp_data = pend; end
      end
      if (mem_req_valid && stall_left > 0 && mem_req_addr == stall_addr) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni && mem_rsp_valid) begin
      assert (!(mem_req_valid || ifu_valid || ftq_rsp.ready))
      else begin
        fails++;
        $error("FAIL mem_protocol: response while not waiting (req_valid=%b ifu_valid=%b ready=%b)",
               mem_req_valid, ifu_valid, ftq_rsp.ready);
      end
    end
  end

  logic [31:0] addr_q[$];
  logic [31:0] stall_q[$];

  // call at a negedge with the DUT idle; returns at the negedge of cycle T+1
  task automatic start_fetch(input logic [31:0] va);
    ftq_req.valid = 1'b1;
    ftq_req.vaddr = va;
    @(negedge clk);
    ftq_req.valid = 1'b0;
  endtask

  task automatic wait_ifu(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      if (mem_req_valid && mem_req_ready) addr_q.push_back(mem_req_addr);
      if (mem_req_valid && !mem_req_ready) stall_q.push_back(mem_req_addr);
      if (ifu_valid) begin cyc = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic finish_pkt;
    ifu_ready = 1'b1;
    @(negedge clk);
    ifu_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (ftq_rsp.ready !== 1'b1) begin fails++; $display("FAIL reset_ftq_ready: got %b want 1", ftq_rsp.ready); end
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); end
    tests++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", mem_req_addr); end
    tests++; if (ifu_valid !== 1'b0) begin fails++; $display("FAIL reset_ifu_valid: got %b want 0", ifu_valid); end
    tests++; if (ifu_pc !== 32'h0) begin fails++; $display("FAIL reset_ifu_pc: got %h want 0", ifu_pc); end
    tests++; if (ifu_data !== 128'h0) begin fails++; $display("FAIL reset_ifu_data: got %h want 0", ifu_data); end
    rst_ni = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    tests++; if (ftq_rsp.ready !== 1'b0) begin fails++; $display("FAIL idle_flush_ready: got %b want 0", ftq_rsp.ready); end
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    lat = 1; addr_q.delete(); stall_q.delete();
    start_fetch(32'h8000_0000);
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
      fails++; $display("FAIL basic_first_req: got valid=%b addr=%h want 1/80000000", mem_req_valid, mem_req_addr); end
    wait_ifu(40, cyc);
    tests++; if (cyc != 9) begin fails++; $display("FAIL basic_latency: got %0d want 9", cyc); end
    tests++; if (addr_q.size() != 4) begin fails++; $display("FAIL basic_req_count: got %0d want 4", addr_q.size()); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] got, exp;
      exp = 32'h8000_0000 + 32'(k * 4);
      got = (k < addr_q.size()) ? addr_q[k] : 32'hxxxx_xxxx;
      tests++; if (got !== exp) begin fails++; $display("FAIL basic_addr%0d: got %h want %h", k, got, exp); end
    end
    tests++; if (ifu_data !== {32'h8000_000C, 32'h8000_0008, 32'h8000_0004, 32'h8000_0000}) begin
      fails++; $display("FAIL basic_data: got %h", ifu_data); end
    tests++; if (ifu_pc !== 32'h8000_0000) begin fails++; $display("FAIL basic_pc: got %h want 80000000", ifu_pc); end
    finish_pkt();
    tests++; if (ifu_valid !== 1'b0 || ftq_rsp.ready !== 1'b1) begin
      fails++; $display("FAIL basic_after_hs: got valid=%b ready=%b want 0/1", ifu_valid, ftq_rsp.ready); end
  endtask

  task automatic test_backpressure;
    int cyc;
    lat = 1; addr_q.delete(); stall_q.delete();
    start_fetch(32'h0000_1000);
    wait_ifu(40, cyc);
    tests++; if (cyc != 9) begin fails++; $display("FAIL bp_latency: got %0d want 9", cyc); end
    ftq_req.valid = 1'b1;
    ftq_req.vaddr = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      tests++; if (ifu_valid !== 1'b1 || ifu_pc !== 32'h1000 ||
                   ifu_data !== {32'h100C, 32'h1008, 32'h1004, 32'h1000}) begin
        fails++; $display("FAIL bp_stable%0d: got valid=%b pc=%h data=%h", i, ifu_valid, ifu_pc, ifu_data); end
      tests++; if (ftq_rsp.ready !== 1'b0) begin fails++; $display("FAIL bp_ftq_ready%0d: got %b want 0", i, ftq_rsp.ready); end
      @(negedge clk);
    end
    ifu_ready = 1'b1;
    @(negedge clk);
    ifu_ready = 1'b0;
    tests++; if (ftq_rsp.ready !== 1'b1 || ifu_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", ftq_rsp.ready, ifu_valid); end
    @(negedge clk);
    ftq_req.valid = 1'b0;
    addr_q.delete();
    tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000) begin
      fails++; $display("FAIL bp_next_req: got valid=%b addr=%h want 1/00002000", mem_req_valid, mem_req_addr); end
    wait_ifu(40, cyc);
    tests++; if (cyc != 9 || ifu_data !== {32'h200C, 32'h2008, 32'h2004, 32'h2000}) begin
      fails++; $display("FAIL bp_second_pkt: got cyc=%0d data=%h", cyc, ifu_data); end
    finish_pkt();
  endtask

  task automatic test_mem_stall;
    int cyc;
    lat = 1; addr_q.delete(); stall_q.delete();
    stall_addr = 32'h3008; stall_left = 3;
    start_fetch(32'h0000_3000);
    wait_ifu(40, cyc);
    tests++; if (cyc != 12) begin fails++; $display("FAIL stall_latency: got %0d want 12", cyc); end
    tests++; if (stall_q.size() != 3) begin fails++; $display("FAIL stall_cycles: got %0d want 3", stall_q.size()); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] got;
      got = (k < stall_q.size()) ? stall_q[k] : 32'hxxxx_xxxx;
      tests++; if (got !== 32'h3008) begin fails++; $display("FAIL stall_addr%0d: got %h want 00003008", k, got); end
    end
    tests++; if (ifu_data !== {32'h300C, 32'h3008, 32'h3004, 32'h3000}) begin
      fails++; $display("FAIL stall_data: got %h", ifu_data); end
    finish_pkt();
  endtask

  task automatic test_flush_wait;
    int cyc;
    bit found, stale;
    lat = 4; addr_q.delete(); stall_q.delete();
    start_fetch(32'h0000_4000);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req_valid && mem_req_ready && mem_req_addr == 32'h4004) begin found = 1; break; end
      @(negedge clk);
    end
    tests++; if (!found) begin fails++; $display("FAIL fw_word1_req: got none want addr 00004004"); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ftq_req.valid = 1'b1;
    ftq_req.vaddr = 32'h0000_5000;
    #1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      tests++; if (ftq_rsp.ready !== 1'b0 || ifu_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
        fails++; $display("FAIL fw_drain%0d: got ready=%b ifu_valid=%b req_valid=%b want 0/0/0",
                          i, ftq_rsp.ready, ifu_valid, mem_req_valid); end
      if (mem_rsp_valid) begin stale = 1; break; end
      @(negedge clk);
    end
    tests++; if (!stale) begin fails++; $display("FAIL fw_stale_rsp: got none want one"); end
    @(negedge clk);
    lat = 1;
    tests++; if (ftq_rsp.ready !== 1'b1) begin fails++; $display("FAIL fw_accept: got %b want 1", ftq_rsp.ready); end
    @(negedge clk);
    ftq_req.valid = 1'b0;
    addr_q.delete();
    wait_ifu(40, cyc);
    tests++; if (cyc != 9 || ifu_pc !== 32'h5000 || ifu_data !== {32'h500C, 32'h5008, 32'h5004, 32'h5000}) begin
      fails++; $display("FAIL fw_fresh_pkt: got cyc=%0d pc=%h data=%h", cyc, ifu_pc, ifu_data); end
    finish_pkt();
  endtask

  task automatic test_flush_corners;
    int cyc, n;
    lat = 1;
    start_fetch(32'h0000_6000);
    tests++; if (mem_req_valid !== 1'b1 || mem_req_ready !== 1'b1) begin
      fails++; $display("FAIL fc_req_hs: got valid=%b ready=%b want 1/1", mem_req_valid, mem_req_ready); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++; if (ftq_rsp.ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL fc_hs_drain: got ready=%b req_valid=%b want 0/0", ftq_rsp.ready, mem_req_valid); end
    @(negedge clk);
    tests++; if (ftq_rsp.ready !== 1'b1) begin fails++; $display("FAIL fc_hs_idle: got %b want 1", ftq_rsp.ready); end

    start_fetch(32'h0000_7000);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_rsp_valid) begin
        n++;
        if (n == 4) begin flush = 1'b1; break; end
      end
      @(negedge clk);
    end
    tests++; if (n != 4) begin fails++; $display("FAIL fc_last_rsp: got %0d responses want 4", n); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++; if (ifu_valid !== 1'b0 || ftq_rsp.ready !== 1'b1) begin
      fails++; $display("FAIL fc_last_idle: got valid=%b ready=%b want 0/1", ifu_valid, ftq_rsp.ready); end
    @(negedge clk);

    start_fetch(32'h0000_7100);
    wait_ifu(40, cyc);
    tests++; if (cyc != 9) begin fails++; $display("FAIL fc_resp_latency: got %0d want 9", cyc); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++; if (ifu_valid !== 1'b0 || ftq_rsp.ready !== 1'b1) begin
      fails++; $display("FAIL fc_resp_drop: got valid=%b ready=%b want 0/1", ifu_valid, ftq_rsp.ready); end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int cyc;
    logic [31:0] exp[4];
    exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    lat = 1; addr_q.delete(); stall_q.delete();
    start_fetch(32'hFFFF_FFF8);
    wait_ifu(40, cyc);
    tests++; if (addr_q.size() != 4) begin fails++; $display("FAIL wrap_req_count: got %0d want 4", addr_q.size()); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] got;
      got = (k < addr_q.size()) ? addr_q[k] : 32'hxxxx_xxxx;
      tests++; if (got !== exp[k]) begin fails++; $display("FAIL wrap_addr%0d: got %h want %h", k, got, exp[k]); end
    end
    tests++; if (cyc != 9 || ifu_data !== {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8}) begin
      fails++; $display("FAIL wrap_data: got cyc=%0d data=%h", cyc, ifu_data); end
    finish_pkt();
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit found;
    lat = 4;
    start_fetch(32'h0000_9000);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid && mem_req_ready) begin found = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    tests++; if (!found || mem_req_valid !== 1'b0 || ftq_rsp.ready !== 1'b0) begin
      fails++; $display("FAIL rm_in_wait: got found=%b req_valid=%b ready=%b want 1/0/0", found, mem_req_valid, ftq_rsp.ready); end
    #2 rst_ni = 1'b0;
    #1;
    tests++; if (ftq_rsp.ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 ||
                 ifu_valid !== 1'b0 || ifu_pc !== 32'h0 || ifu_data !== 128'h0) begin
      fails++; $display("FAIL rm_async: got ready=%b req=%b addr=%h ifu=%b pc=%h data=%h",
                        ftq_rsp.ready, mem_req_valid, mem_req_addr, ifu_valid, ifu_pc, ifu_data); end
    @(negedge clk);
    rst_ni = 1'b1;
    lat = 1;
    @(negedge clk);
    addr_q.delete();
    start_fetch(32'h0000_A000);
    wait_ifu(40, cyc);
    tests++; if (cyc != 9 || ifu_data !== {32'hA00C, 32'hA008, 32'hA004, 32'hA000}) begin
      fails++; $display("FAIL rm_after: got cyc=%0d data=%h", cyc, ifu_data); end
    finish_pkt();
  endtask

  initial begin
    rst_ni = 1'b1;
    flush = 1'b0;
    ftq_req = '0;
    ifu_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_mem_stall();
    test_flush_wait();
    test_flush_corners();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
